// File: rtl/vending_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vending_controller: coin accumulation, vend/refund sequencing FSM     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module vending_controller #(
  parameter int PRICE          = 20,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DEP_W          = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             nickel_i,
  input  logic             dime_i,
  input  logic             quarter_i,
  input  logic             cancel_i,
  output logic [DEP_W-1:0] deposit_o,
  output logic             exceed_o,
  output logic             refund_o,
  output logic [DEP_W-1:0] refund_amt_o,
  output logic             reject_o,
  output logic             busy_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DEP_W-1:0] PRICE_V  = DEP_W'(PRICE);
  localparam logic [DEP_W-1:0] VAL_5    = DEP_W'(5);
  localparam logic [DEP_W-1:0] VAL_10   = DEP_W'(10);
  localparam logic [DEP_W-1:0] VAL_25   = DEP_W'(25);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_VEND     = 3'd2,
    S_COOLDOWN = 3'd3,
    S_REFUND   = 3'd4
  } state_e;

  state_e           state_q;
  logic [DEP_W-1:0] deposit_q;
  logic [DEP_W-1:0] refund_amt_q;
  logic             exceed_q;
  logic             refund_q;
  logic             reject_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic             coin_vld;
  logic [DEP_W-1:0] coin_val;
  logic [DEP_W-1:0] deposit_d;

  // Only the highest-value coin of a multi-pulse cycle counts.
  always_comb begin
    coin_vld = quarter_i | dime_i | nickel_i;
    coin_val = '0;
    if (quarter_i)     coin_val = VAL_25;
    else if (dime_i)   coin_val = VAL_10;
    else if (nickel_i) coin_val = VAL_5;
    deposit_d = deposit_q + coin_val;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      deposit_q    <= '0;
      refund_amt_q <= '0;
      exceed_q     <= 1'b0;
      refund_q     <= 1'b0;
      reject_q     <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      exceed_q     <= 1'b0;
      refund_q     <= 1'b0;
      refund_amt_q <= '0;
      reject_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (coin_vld) begin
            if (cancel_i) begin
              state_q      <= S_REFUND;
              refund_q     <= 1'b1;
              refund_amt_q <= coin_val;
              deposit_q    <= '0;
              busy_q       <= 1'b1;
            end else if (coin_val >= PRICE_V) begin
              state_q   <= S_VEND;
              exceed_q  <= 1'b1;
              deposit_q <= coin_val;
              busy_q    <= 1'b1;
            end else begin
              state_q   <= S_COLLECT;
              deposit_q <= coin_val;
              cnt_q     <= '0;
            end
          end
        end
        S_COLLECT: begin
          // With no coin deposit_d equals deposit_q, so one path covers both.
          if (cancel_i) begin
            state_q      <= S_REFUND;
            refund_q     <= 1'b1;
            refund_amt_q <= deposit_d;
            deposit_q    <= '0;
            busy_q       <= 1'b1;
          end else if (coin_vld) begin
            if (deposit_d >= PRICE_V) begin
              state_q  <= S_VEND;
              exceed_q <= 1'b1;
              busy_q   <= 1'b1;
            end
            deposit_q <= deposit_d;
            cnt_q     <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= S_REFUND;
            refund_q     <= 1'b1;
            refund_amt_q <= deposit_q;
            deposit_q    <= '0;
            busy_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_VEND: begin
          state_q  <= S_COOLDOWN;
          reject_q <= coin_vld;
        end
        S_COOLDOWN: begin
          state_q   <= S_IDLE;
          deposit_q <= '0;
          busy_q    <= 1'b0;
          reject_q  <= coin_vld;
        end
        S_REFUND: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          reject_q <= coin_vld;
        end
        default: begin
          state_q   <= S_IDLE;
          deposit_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign deposit_o    = deposit_q;
  assign exceed_o     = exceed_q;
  assign refund_o     = refund_q;
  assign refund_amt_o = refund_amt_q;
  assign reject_o     = reject_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vending_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vending_controller: directed and random checks of vending_controller|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_vending_controller;

  localparam int PRICE   = 20;
  localparam int TIMEOUT = 4;
  localparam int DEP_W   = 6;
  localparam int VW      = 2 * DEP_W + 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             nickel_i = 1'b0, dime_i = 1'b0, quarter_i = 1'b0, cancel_i = 1'b0;
  logic [DEP_W-1:0] deposit_o, refund_amt_o;
  logic             exceed_o, refund_o, reject_o, busy_o;
  logic [VW-1:0]    observed;

  int checks = 0;
  int errors = 0;

  vending_controller #(.PRICE(PRICE), .TIMEOUT_CYCLES(TIMEOUT), .DEP_W(DEP_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .nickel_i(nickel_i), .dime_i(dime_i), .quarter_i(quarter_i), .cancel_i(cancel_i),
    .deposit_o(deposit_o), .exceed_o(exceed_o), .refund_o(refund_o),
    .refund_amt_o(refund_amt_o), .reject_o(reject_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Field order: deposit, exceed, refund, refund_amt, reject, busy.
  assign observed = {deposit_o, exceed_o, refund_o, refund_amt_o, reject_o, busy_o};

  function automatic logic [VW-1:0] pack(int dep, bit exc, bit rf, int amt, bit rej, bit busy);
    return {DEP_W'(dep), exc, rf, DEP_W'(amt), rej, busy};
  endfunction

  // Reference model: a customer transaction either accumulates money or,
  // once decided (vend/refund), plays out a fixed script of output frames
  // during which the machine is deaf to coins.
  logic [VW-1:0] exp_vec = '0;
  logic [VW-1:0] script[$];
  bit            m_collect = 1'b0;
  int            m_dep = 0;
  int            m_idle = 0;

  task automatic model_step(input logic [3:0] s, input logic rst);
    int v;
    int sum;
    if (!rst) begin
      script.delete();
      m_collect = 1'b0; m_dep = 0; m_idle = 0; exp_vec = '0;
      return;
    end
    v = s[1] ? 25 : (s[2] ? 10 : (s[3] ? 5 : 0));
    if (script.size() > 0) begin
      exp_vec    = script.pop_front();
      exp_vec[1] = (v != 0);
      return;
    end
    sum = m_dep + v;
    if (s[0] && (m_collect || v != 0)) begin
      m_collect = 1'b0; m_dep = 0;
      exp_vec = pack(0, 0, 1, sum, 0, 1);
      script.push_back(pack(0, 0, 0, 0, 0, 0));
    end else if (v != 0 && sum >= PRICE) begin
      m_collect = 1'b0; m_dep = 0;
      exp_vec = pack(sum, 1, 0, 0, 0, 1);
      script.push_back(pack(sum, 0, 0, 0, 0, 1));
      script.push_back(pack(0, 0, 0, 0, 0, 0));
    end else if (v != 0) begin
      m_collect = 1'b1; m_dep = sum; m_idle = 0;
      exp_vec = pack(sum, 0, 0, 0, 0, 0);
    end else if (m_collect && m_idle + 1 >= TIMEOUT) begin
      exp_vec = pack(0, 0, 1, m_dep, 0, 1);
      m_collect = 1'b0; m_dep = 0;
      script.push_back(pack(0, 0, 0, 0, 0, 0));
    end else begin
      if (m_collect) m_idle++;
      exp_vec = pack(m_dep, 0, 0, 0, 0, 0);
    end
  endtask

  // s = {nickel, dime, quarter, cancel}
  task automatic tick(input logic [3:0] s, input logic rst);
    {nickel_i, dime_i, quarter_i, cancel_i} = s;
    rst_ni = rst;
    @(posedge clk_i);
    model_step(s, rst);
    #1;
    {nickel_i, dime_i, quarter_i, cancel_i} = 4'b0000;
  endtask

  task automatic test_reset();
    logic [3:0]    st [7] = '{4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic          rs [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [VW-1:0] ex [7] = '{pack(0,0,0,0,0,0), pack(0,0,0,0,0,0), pack(5,0,0,0,0,0),
                              pack(15,0,0,0,0,0), pack(0,0,0,0,0,0), pack(0,0,0,0,0,0),
                              pack(0,0,0,0,0,0)};
    for (int i = 0; i < 7; i++) begin
      tick(st[i], rs[i]);
      checks++;
      if (observed !== ex[i]) begin
        errors++;
        $display("FAIL reset step %0d: observed %h expected %h", i, observed, ex[i]);
      end
    end
  endtask

  task automatic test_exact_price();
    logic [3:0]    st [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [VW-1:0] ex [4] = '{pack(10,0,0,0,0,0), pack(20,1,0,0,0,1),
                              pack(20,0,0,0,0,1), pack(0,0,0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      tick(st[i], 1'b1);
      checks++;
      if (observed !== ex[i]) begin
        errors++;
        $display("FAIL exact_price step %0d: observed %h expected %h", i, observed, ex[i]);
      end
    end
  endtask

  task automatic test_overpay();
    logic [3:0]    st [5] = '{4'b0100, 4'b1000, 4'b0010, 4'b0000, 4'b0000};
    logic [VW-1:0] ex [5] = '{pack(10,0,0,0,0,0), pack(15,0,0,0,0,0), pack(40,1,0,0,0,1),
                              pack(40,0,0,0,0,1), pack(0,0,0,0,0,0)};
    for (int i = 0; i < 5; i++) begin
      tick(st[i], 1'b1);
      checks++;
      if (observed !== ex[i]) begin
        errors++;
        $display("FAIL overpay step %0d: observed %h expected %h", i, observed, ex[i]);
      end
    end
  endtask

  task automatic test_cancel_coin();
    logic [3:0]    st [4] = '{4'b0001, 4'b1000, 4'b0101, 4'b0000};
    logic [VW-1:0] ex [4] = '{pack(0,0,0,0,0,0), pack(5,0,0,0,0,0),
                              pack(0,0,1,15,0,1), pack(0,0,0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      tick(st[i], 1'b1);
      checks++;
      if (observed !== ex[i]) begin
        errors++;
        $display("FAIL cancel_coin step %0d: observed %h expected %h", i, observed, ex[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0]    st [6] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [VW-1:0] ex [6] = '{pack(10,0,0,0,0,0), pack(10,0,0,0,0,0), pack(10,0,0,0,0,0),
                              pack(10,0,0,0,0,0), pack(0,0,1,10,0,1), pack(0,0,0,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      tick(st[i], 1'b1);
      checks++;
      if (observed !== ex[i]) begin
        errors++;
        $display("FAIL timeout step %0d: observed %h expected %h", i, observed, ex[i]);
      end
    end
  endtask

  task automatic test_priority_busy();
    logic [3:0]    st [4] = '{4'b1010, 4'b0100, 4'b0000, 4'b0000};
    logic [VW-1:0] ex [4] = '{pack(25,1,0,0,0,1), pack(25,0,0,0,1,1),
                              pack(0,0,0,0,0,0), pack(0,0,0,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      tick(st[i], 1'b1);
      checks++;
      if (observed !== ex[i]) begin
        errors++;
        $display("FAIL priority_busy step %0d: observed %h expected %h", i, observed, ex[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] s;
    logic       rst;
    int         r;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      s = 4'b0000;
      if (r < 12)      s[3] = 1'b1;
      else if (r < 20) s[2] = 1'b1;
      else if (r < 26) s[1] = 1'b1;
      else if (r < 32) s[3:1] = 3'($urandom_range(1, 7));
      s[0] = ($urandom_range(0, 14) == 0);
      rst  = ($urandom_range(0, 199) != 0);
      tick(s, rst);
      checks++;
      if (observed !== exp_vec) begin
        errors++;
        $display("FAIL random cycle %0d: observed %h expected %h (stim %b rst %b)",
                 i, observed, exp_vec, s, rst);
      end
      checks++;
      if (exceed_o && refund_o) begin
        errors++;
        $display("FAIL random exclusive cycle %0d: exceed %b refund %b required not both",
                 i, exceed_o, refund_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_overpay();
    test_cancel_coin();
    test_timeout();
    test_priority_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
